stride_prefetcher: RTL and testbench
====================================

// Module: stride_prefetcher
// PURPOSE
//  Downstream consumer of the stride detector. Watches the same value stream the detector sees.
//  Takes the detector's confident stride outputs and issues a burst of predicted next addresses
//  over a valid/ready port toward the prefetch request queue.
//  Supports a one-stride pattern (a, a+s, a+2s..) and an alternating two-stride pattern (a, a+s0, a+s0+s1..).
// PARAMETERS
//  MAX_STRIDE_WIDTH  5  width of the detector stride fields; strides are two's-complement signed
//  PREFETCH_DEPTH    4  predicted addresses issued per trigger (>=1, <=16)
// PORTS
//  clk_i             in   1   clock; single clock domain
//  rst_i             in   1   synchronous, active-high reset
//  value_i           in   32  observed value/address; same stream as the detector's input
//  valid_i           in   1   value_i valid this cycle
//  stride_1_i        in   MSW detector stride_1 output (signed)
//  stride_1_valid_i  in   1   detector stride_1 confident
//  stride_2_i        in   MSW detector stride_2 output (signed)
//  stride_2_valid_i  in   1   detector two-stride pattern confident
//  pf_addr_o         out  32  predicted address
//  pf_valid_o        out  1   pf_addr_o valid
//  pf_ready_i        in   1   downstream accepts pf_addr_o when high together with pf_valid_o
//  pf_mode_o         out  2   mode of the current burst: pf_mode_e (NONE=0, ONE=1, TWO=2)
//  busy_o            out  1   burst in progress (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; pf_valid_o=0, pf_addr_o=0, pf_mode_o=NONE, busy_o=0; phase=0, count=0.
//  Phase bit: toggles on every valid_i cycle, regardless of state or mode, and never otherwise.
//   It mirrors the detector's slot alternation: after the toggle, phase=1 means the next stride is slot 0 (stride_1_i).
//   phase=0 means the next stride is slot 1 (stride_2_i).
//  Mode select at a valid_i cycle: stride_2_valid_i -> TWO, else stride_1_valid_i -> ONE, else NONE.
//   Stride inputs are sampled in the same cycle as value_i.
//  Trigger: valid_i with mode != NONE, and not all used strides zero.
//   All used strides zero means ONE with s=0, or TWO with s0=s1=0.
//   On trigger, the following are captured:
//   - base = value_i
//   - s0 = sext(stride_1_i), s1 = sext(stride_2_i), sign-extended to 32 bits
//   - mode
//   - slot = new phase value (1 -> s0 first)
//   - count = 0
//  Trigger effect next cycle: state=ISSUE, pf_valid_o=1.
//   pf_addr_o = base + step, with step = s0 in ONE mode, and the slot-selected stride in TWO mode. Latency 1 cycle.
//  Arithmetic: all addition is modulo 2^32; wrap-around is silent. No overflow flag.
//  ISSUE handshake (pf_valid_o & pf_ready_i):
//   - base <= pf_addr_o, count++, slot toggles (TWO only).
//   - Next address presented the following cycle; no bubble.
//   - Accept with count == PREFETCH_DEPTH-1: state=IDLE, pf_valid_o=0, pf_mode_o=NONE.
//  Stall: while pf_valid_o & !pf_ready_i, pf_addr_o and pf_mode_o are held stable.
//   Only exception: restart (below).
//  Restart: a trigger while in ISSUE aborts the current burst and loads the new one.
//   The new burst's first address appears next cycle. pf_valid_o stays high.
//   Restart in the same cycle as a handshake: the accepted address counts as delivered; the new burst still wins.
//  Non-trigger valid_i in ISSUE: the burst continues unchanged; phase still toggles.
//   The non-trigger cases are mode NONE and zero strides.
//  valid_i in IDLE without trigger: phase toggles only.
//  Reset mid-burst: all state returns to reset values the next cycle, including phase.
//   This matches the detector, which is reset together with this block.
//  FSM: IDLE -(trigger)-> ISSUE; ISSUE -(last accept, no trigger)-> IDLE;
//   ISSUE -(trigger)-> ISSUE (restart).
// STRUCTURE
//  stride_pkg:
//   - pf_mode_e enum {PF_NONE, PF_ONE, PF_TWO}, logic[1:0]
//   - pf_state_e {PF_IDLE, PF_ISSUE}
//   - sext_stride function (MSW->32)
//  Single flat module. Sequential logic is one register block, with next-state in always_comb.
//  Count width is $clog2(PREFETCH_DEPTH)+1. No sub-module is warranted.
// TESTING
//  1 ONE mode, stride_1=4, value 0x100, ready=1, DEPTH=4 -> 0x104,0x108,0x10C,0x110 on consecutive cycles, then valid=0, busy=0.
//  2 Negative wrap: stride_1=5'h1D (-3), value 0x2 -> 0xFFFFFFFF, 0xFFFFFFFC, 0xFFFFFFF9, 0xFFFFFFF6.
//  3 TWO mode: s0=1, s1=3. Value 0x10 arrives on the 3rd valid_i since reset (phase=1 after toggle) -> 0x11, 0x14, 0x15, 0x18.
//    Same inputs on the 4th valid_i -> 0x13, 0x14, 0x17, 0x18.
//  4 Backpressure: ready held low 5 cycles after the first address -> pf_addr_o stable, count unchanged, then the burst resumes intact.
//  5 Restart mid-burst: retrigger with value 0x200, stride 8, after the 2nd accept -> the next cycle shows 0x208.
//    Simultaneous accept and retrigger -> the accept is counted and 0x208 follows.
//  6 Zero/none: stride_1_valid_i=0, or stride 0 -> no pf_valid_o, phase still toggles.
//    rst_i during ISSUE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stride_pkg.sv
// Shared types for the stride prefetcher.
// Burst modes, FSM states and stride sign-extension.
package stride_pkg;

  typedef enum logic [1:0] {
    PF_NONE = 2'd0,
    PF_ONE  = 2'd1,
    PF_TWO  = 2'd2
  } pf_mode_e;

  typedef enum logic {
    PF_IDLE  = 1'b0,
    PF_ISSUE = 1'b1
  } pf_state_e;

  // raw holds a w-bit stride zero-extended; return it sign-extended
  function automatic logic [31:0] sext_stride(
    input logic [31:0] raw,
    input int unsigned w
  );
    logic signed [31:0] t;
    t = signed'(raw << (32 - w));
    return 32'(t >>> (32 - w));
  endfunction

endpackage

// File: rtl/stride_prefetcher.sv
// Issues bursts of predicted addresses from detector strides.
// One-stride and alternating two-stride patterns over valid/ready.
module stride_prefetcher
  import stride_pkg::*;
#(
  parameter int MAX_STRIDE_WIDTH = 5,
  parameter int PREFETCH_DEPTH   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [31:0]                 value_i,
  input  logic                        valid_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_1_i,
  input  logic                        stride_1_valid_i,
  input  logic [MAX_STRIDE_WIDTH-1:0] stride_2_i,
  input  logic                        stride_2_valid_i,
  output logic [31:0]                 pf_addr_o,
  output logic                        pf_valid_o,
  input  logic                        pf_ready_i,
  output logic [1:0]                  pf_mode_o,
  output logic                        busy_o
);

  localparam int unsigned MSW = MAX_STRIDE_WIDTH;
  localparam int CW = $clog2(PREFETCH_DEPTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(PREFETCH_DEPTH - 1);

  pf_state_e     state_q, state_d;
  pf_mode_e      mode_q, mode_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   s0_q, s0_d;
  logic [31:0]   s1_q, s1_d;
  logic          slot_q, slot_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] in_s0;
  logic [31:0] in_s1;
  pf_mode_e    in_mode;
  logic        all_zero;
  logic        trigger;
  logic        accept;
  logic        slot_nx;

  always_comb begin
    in_s0    = sext_stride(32'(stride_1_i), MSW);
    in_s1    = sext_stride(32'(stride_2_i), MSW);
    in_mode  = PF_NONE;
    if (stride_2_valid_i) begin
      in_mode = PF_TWO;
    end else if (stride_1_valid_i) begin
      in_mode = PF_ONE;
    end
    if (in_mode == PF_TWO) begin
      all_zero = (in_s0 == '0) && (in_s1 == '0);
    end else begin
      all_zero = (in_s0 == '0);
    end
    trigger = valid_i && (in_mode != PF_NONE) && !all_zero;
    accept  = (state_q == PF_ISSUE) && pf_ready_i;
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    slot_d  = slot_q;
    count_d = count_q;
    phase_d = phase_q ^ valid_i;
    slot_nx = slot_q;
    if (trigger) begin
      // a new trigger wins even over a same-cycle accept
      state_d = PF_ISSUE;
      mode_d  = in_mode;
      s0_d    = in_s0;
      s1_d    = in_s1;
      slot_d  = phase_d;
      count_d = '0;
      if ((in_mode == PF_TWO) && !phase_d) begin
        addr_d = value_i + in_s1;
      end else begin
        addr_d = value_i + in_s0;
      end
    end else if (accept) begin
      if (count_q == LAST) begin
        state_d = PF_IDLE;
        mode_d  = PF_NONE;
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
        slot_nx = (mode_q == PF_TWO) ? !slot_q : slot_q;
        slot_d  = slot_nx;
        if ((mode_q == PF_TWO) && !slot_nx) begin
          addr_d = addr_q + s1_q;
        end else begin
          addr_d = addr_q + s0_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PF_IDLE;
      mode_q  <= PF_NONE;
      addr_q  <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      slot_q  <= 1'b0;
      phase_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      slot_q  <= slot_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign pf_valid_o = (state_q == PF_ISSUE);
  assign busy_o     = (state_q == PF_ISSUE);
  assign pf_addr_o  = addr_q;
  assign pf_mode_o  = mode_q;

endmodule

// File: tb/tb_stride_prefetcher.sv
// Testbench for stride_prefetcher: directed scenarios plus
// randomized traffic against a burst-list reference model.
module tb_stride_prefetcher;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        valid;
  logic [4:0]  st1;
  logic        s1v;
  logic [4:0]  st2;
  logic        s2v;
  logic        ready;
  logic [31:0] pf_addr_o;
  logic        pf_valid_o;
  logic [1:0]  pf_mode_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] got[$];
  logic [31:0] mq[$];
  int          m_mode;
  bit          m_phase;

  always #5 clk = !clk;

  stride_prefetcher #(
    .MAX_STRIDE_WIDTH(5),
    .PREFETCH_DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .value_i(value),
    .valid_i(valid),
    .stride_1_i(st1),
    .stride_1_valid_i(s1v),
    .stride_2_i(st2),
    .stride_2_valid_i(s2v),
    .pf_addr_o(pf_addr_o),
    .pf_valid_o(pf_valid_o),
    .pf_ready_i(ready),
    .pf_mode_o(pf_mode_o),
    .busy_o(busy_o)
  );

  function automatic int sx(logic [4:0] s);
    int v;
    v = int'(s);
    if (v >= 16) v -= 32;
    return v;
  endfunction

  // one clock: log delivered addresses, advance the reference model
  task automatic tick();
    if (pf_valid_o && ready) got.push_back(pf_addr_o);
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_mode  = 0;
      m_phase = 0;
    end else begin
      if (mq.size() > 0 && ready) void'(mq.pop_front());
      if (valid) begin
        int md;
        int a;
        int b;
        logic [31:0] x;
        m_phase = !m_phase;
        md = s2v ? 2 : (s1v ? 1 : 0);
        a = sx(st1);
        b = sx(st2);
        if (md != 0 && !(a == 0 && (md == 1 || b == 0))) begin
          mq.delete();
          x = value;
          for (int k = 0; k < D; k++) begin
            if (md == 1 || ((k % 2 == 0) == m_phase)) x += a;
            else x += b;
            mq.push_back(x);
          end
          m_mode = md;
        end
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; value = '0; st1 = '0; st2 = '0;
    s1v = 0; s2v = 0; ready = 1;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
    got.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    total++;
    if (pf_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%b/%b exp=0/0", pf_valid_o, busy_o);
    end
    total++;
    if (pf_addr_o !== 32'h0 || pf_mode_o !== 2'd0) begin
      bad++;
      $display("FAIL reset_addr got=%h/%0d exp=0/0", pf_addr_o, pf_mode_o);
    end
    rst = 0;
    got.delete();
  endtask

  task automatic test_one();
    logic [31:0] exp[$];
    reset_dut();
    valid = 1; value = 32'h100; st1 = 5'd4; s1v = 1;
    tick();
    idle_inputs();
    total++;
    if (pf_valid_o !== 1'b1 || pf_addr_o !== 32'h104 || pf_mode_o !== 2'd1) begin
      bad++;
      $display("FAIL one_first got=%b %h %0d exp=1 104 1", pf_valid_o, pf_addr_o, pf_mode_o);
    end
    repeat (4) tick();
    total++;
    if (pf_valid_o !== 1'b0 || busy_o !== 1'b0 || pf_mode_o !== 2'd0) begin
      bad++;
      $display("FAIL one_end got=%b/%b/%0d exp=0/0/0", pf_valid_o, busy_o, pf_mode_o);
    end
    exp = '{32'h104, 32'h108, 32'h10C, 32'h110};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL one_seq got=%p exp=%p", got, exp);
    end
  endtask

  task automatic test_neg_wrap();
    logic [31:0] exp[$];
    reset_dut();
    valid = 1; value = 32'h2; st1 = 5'h1D; s1v = 1;
    tick();
    idle_inputs();
    repeat (5) tick();
    exp = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF9, 32'hFFFFFFF6};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL neg_seq got=%p exp=%p", got, exp);
    end
  endtask

  task automatic test_two();
    logic [31:0] exp[$];
    reset_dut();
    valid = 1;
    tick();
    tick();
    value = 32'h10; st1 = 5'd1; st2 = 5'd3; s1v = 1; s2v = 1;
    tick();
    valid = 0;
    total++;
    if (pf_mode_o !== 2'd2 || pf_addr_o !== 32'h11) begin
      bad++;
      $display("FAIL two_first got=%0d %h exp=2 11", pf_mode_o, pf_addr_o);
    end
    repeat (4) tick();
    exp = '{32'h11, 32'h14, 32'h15, 32'h18};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL two_seq_p1 got=%p exp=%p", got, exp);
    end
    got.delete();
    valid = 1;
    tick();
    valid = 0;
    repeat (4) tick();
    exp = '{32'h13, 32'h14, 32'h17, 32'h18};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL two_seq_p0 got=%p exp=%p", got, exp);
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp[$];
    reset_dut();
    ready = 0;
    valid = 1; value = 32'h100; st1 = 5'd4; s1v = 1;
    tick();
    valid = 0; s1v = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (pf_valid_o !== 1'b1 || pf_addr_o !== 32'h104 || pf_mode_o !== 2'd1) begin
        bad++;
        $display("FAIL stall_hold[%0d] got=%b %h %0d exp=1 104 1", i, pf_valid_o, pf_addr_o, pf_mode_o);
      end
    end
    ready = 1;
    repeat (4) tick();
    exp = '{32'h104, 32'h108, 32'h10C, 32'h110};
    total++;
    if (got !== exp || pf_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_seq got=%p v=%b exp=%p v=0", got, pf_valid_o, exp);
    end
  endtask

  task automatic test_restart();
    logic [31:0] exp[$];
    reset_dut();
    valid = 1; value = 32'h100; st1 = 5'd4; s1v = 1;
    tick();
    valid = 0; s1v = 0;
    tick();
    tick();
    ready = 0;
    valid = 1; value = 32'h200; st1 = 5'd8; s1v = 1;
    tick();
    total++;
    if (pf_valid_o !== 1'b1 || pf_addr_o !== 32'h208) begin
      bad++;
      $display("FAIL restart got=%b %h exp=1 208", pf_valid_o, pf_addr_o);
    end
    ready = 1;
    tick();
    total++;
    if (pf_valid_o !== 1'b1 || pf_addr_o !== 32'h208) begin
      bad++;
      $display("FAIL restart_acc got=%b %h exp=1 208", pf_valid_o, pf_addr_o);
    end
    valid = 0; s1v = 0;
    repeat (4) tick();
    exp = '{32'h104, 32'h108, 32'h208, 32'h208, 32'h210, 32'h218, 32'h220};
    total++;
    if (got !== exp || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL restart_seq got=%p b=%b exp=%p b=0", got, busy_o, exp);
    end
  endtask

  task automatic test_zero_none();
    reset_dut();
    valid = 1; value = 32'h40; st1 = 5'd4; s1v = 0;
    tick();
    total++;
    if (pf_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL none_mode got=%b exp=0", pf_valid_o);
    end
    st1 = 5'd0; s1v = 1;
    tick();
    total++;
    if (pf_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_one got=%b exp=0", pf_valid_o);
    end
    s2v = 1; st2 = 5'd0;
    tick();
    total++;
    if (pf_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL zero_two got=%b exp=0", pf_valid_o);
    end
    value = 32'h10; st1 = 5'd1; st2 = 5'd3;
    tick();
    total++;
    if (pf_valid_o !== 1'b1 || pf_addr_o !== 32'h13) begin
      bad++;
      $display("FAIL phase_after_none got=%b %h exp=1 13", pf_valid_o, pf_addr_o);
    end
    valid = 0;
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (pf_valid_o !== 1'b0 || busy_o !== 1'b0 || pf_addr_o !== 32'h0 || pf_mode_o !== 2'd0) begin
      bad++;
      $display("FAIL mid_reset got=%b %b %h %0d exp=0 0 0 0", pf_valid_o, busy_o, pf_addr_o, pf_mode_o);
    end
    valid = 1;
    tick();
    valid = 0;
    total++;
    if (pf_addr_o !== 32'h11 || pf_mode_o !== 2'd2) begin
      bad++;
      $display("FAIL phase_reset got=%h %0d exp=11 2", pf_addr_o, pf_mode_o);
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_random();
    logic        ev;
    logic [31:0] ea;
    logic [1:0]  em;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      valid = ($urandom_range(0, 1) == 1);
      value = $urandom;
      st1   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      st2   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      s1v   = ($urandom_range(0, 9) < 6);
      s2v   = ($urandom_range(0, 9) < 3);
      ready = ($urandom_range(0, 9) < 7);
      tick();
      ev = (mq.size() > 0);
      ea = ev ? mq[0] : 32'h0;
      em = ev ? 2'(m_mode) : 2'd0;
      total++;
      if (pf_valid_o !== ev || busy_o !== ev || pf_mode_o !== em ||
          (ev && pf_addr_o !== ea)) begin
        bad++;
        $display("FAIL rand[%0d] got=%b %b %0d %h exp=%b %b %0d %h",
                 i, pf_valid_o, busy_o, pf_mode_o, pf_addr_o, ev, ev, em, ea);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_one();
    test_neg_wrap();
    test_two();
    test_backpressure();
    test_restart();
    test_zero_none();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
